// File: rtl/disp_arbiter.sv
// disp_arbiter: time-shares a 24-bit hex display among four sources.
// Round-robin rotation with a fixed dwell, urgent preemption (lowest index
// wins) and a switch-selected manual mode that overrides everything else.
module disp_arbiter #(
    parameter int DWELL = 100_000_000,
    parameter int CNT_W = 27
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_req,
    input  logic [3:0]  i_urg,
    input  logic [3:0]  i_upd,
    input  logic [23:0] i_data0,
    input  logic [23:0] i_data1,
    input  logic [23:0] i_data2,
    input  logic [23:0] i_data3,
    input  logic        i_mode,
    input  logic [1:0]  i_sel,
    output logic [23:0] o_data_out,
    output logic [1:0]  o_cur_src,
    output logic        o_src_valid,
    output logic        o_switch_pulse
);

    typedef enum logic [1:0] {IDLE, SHOW, URGENT, MANUAL} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [23:0]      r_shadow [4];
    logic [23:0]      w_data [4];
    logic [1:0]       r_cur_src;
    logic [1:0]       r_last;
    logic [1:0]       w_next_src;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [23:0]      r_data_out;
    logic             r_src_valid;
    logic             r_switch_pulse;
    logic [3:0]       w_er;
    logic [3:0]       w_u;
    logic [2:0]       w_from_cur;
    logic [2:0]       w_from_last;
    logic [1:0]       w_urg_src;

    // First set bit of vec searching start+1, start+2, ... wrapping back to
    // start itself last. Bit 2 of the result flags that something was found.
    function automatic logic [2:0] findNext(input logic [3:0] vec, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = start + 2'(k);
            if (vec[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    // Lowest set index; the caller only uses it when vec is non-zero.
    function automatic logic [1:0] lowestSet(input logic [3:0] vec);
        logic [1:0] result;
        result = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (vec[k]) result = 2'(k);
        end
        return result;
    endfunction

    assign w_data[0]   = i_data0;
    assign w_data[1]   = i_data1;
    assign w_data[2]   = i_data2;
    assign w_data[3]   = i_data3;
    assign w_er        = i_req;
    assign w_u         = i_req & i_urg;
    assign w_from_cur  = findNext(w_er, r_cur_src);
    assign w_from_last = findNext(w_er, r_last);
    assign w_urg_src   = lowestSet(w_u);

    // Next-state, next grant and dwell counter; mode overrides every state.
    always_comb begin
        w_next_state = r_state;
        w_next_src   = r_cur_src;
        w_next_cnt   = '0;
        if (i_mode) begin
            w_next_state = MANUAL;
            w_next_src   = i_sel;
        end else if (w_u != 4'b0000) begin
            w_next_state = URGENT;
            w_next_src   = w_urg_src;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_from_last[2]) begin
                        w_next_state = SHOW;
                        w_next_src   = w_from_last[1:0];
                    end
                end
                SHOW: begin
                    if (!w_er[r_cur_src] || r_cnt == CNT_W'(DWELL - 1)) begin
                        if (w_from_cur[2]) begin
                            w_next_src = w_from_cur[1:0];
                        end else begin
                            w_next_state = IDLE;
                        end
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
                MANUAL: begin
                    if (w_er[r_cur_src]) begin
                        w_next_state = SHOW;
                    end else if (w_from_cur[2]) begin
                        w_next_state = SHOW;
                        w_next_src   = w_from_cur[1:0];
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    if (w_from_cur[2]) begin
                        w_next_state = SHOW;
                        w_next_src   = w_from_cur[1:0];
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            endcase
        end
    end

    // State, grant, round-robin pointer and dwell counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_cur_src      <= 2'd0;
            r_last         <= 2'd3;
            r_cnt          <= '0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cur_src      <= w_next_src;
            r_cnt          <= w_next_cnt;
            r_switch_pulse <= (w_next_src != r_cur_src);
            if (w_next_state == SHOW || w_next_state == URGENT) begin
                r_last <= w_next_src;
            end
        end
    end

    // Shadow capture, independent of grant and mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i_upd[i]) r_shadow[i] <= w_data[i];
            end
        end
    end

    // Display word and its valid flag, one edge behind the grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_out  <= '0;
            r_src_valid <= 1'b0;
        end else begin
            r_data_out  <= (r_state == IDLE) ? 24'h000000 : r_shadow[r_cur_src];
            r_src_valid <= (r_state != IDLE);
        end
    end

    assign o_data_out     = r_data_out;
    assign o_cur_src      = r_cur_src;
    assign o_src_valid    = r_src_valid;
    assign o_switch_pulse = r_switch_pulse;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed checks of reset, rotation, drop, urgent,
// manual and capture behaviour with a short dwell of 8 cycles.
module tb_disp_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  urg;
    logic [3:0]  upd;
    logic [23:0] data0;
    logic [23:0] data1;
    logic [23:0] data2;
    logic [23:0] data3;
    logic        mode;
    logic [1:0]  sel;
    logic [23:0] dataOut;
    logic [1:0]  curSrc;
    logic        srcValid;
    logic        switchPulse;

    int compared   = 0;
    int mismatched = 0;

    disp_arbiter #(.DWELL(8), .CNT_W(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_urg          (urg),
        .i_upd          (upd),
        .i_data0        (data0),
        .i_data1        (data1),
        .i_data2        (data2),
        .i_data3        (data3),
        .i_mode         (mode),
        .i_sel          (sel),
        .o_data_out     (dataOut),
        .o_cur_src      (curSrc),
        .o_src_valid    (srcValid),
        .o_switch_pulse (switchPulse)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge so outputs are stable when sampled.
    task automatic waitEdge(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] u,
                                 input logic [3:0] p, input logic m, input logic [1:0] s);
        req  = r;
        urg  = u;
        upd  = p;
        mode = m;
        sel  = s;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence; edge labels A, B, C, D mark reference points.
    initial begin
        rst_n = 1'b0;
        data0 = 24'hFFFFFF;
        data1 = 24'hFFFFFF;
        data2 = 24'hFFFFFF;
        data3 = 24'hFFFFFF;
        applyStimulus(4'hF, 4'h0, 4'hF, 1'b0, 2'd0);
        waitEdge(2);
        checkOutput("rst_data_out", 32'(dataOut), 32'h000000);
        checkOutput("rst_cur_src", 32'(curSrc), 32'd0);
        checkOutput("rst_src_valid", 32'(srcValid), 32'd0);
        checkOutput("rst_switch_pulse", 32'(switchPulse), 32'd0);

        rst_n = 1'b1;
        upd   = 4'h0;
        waitEdge(1);
        checkOutput("rel_first_grant", 32'(curSrc), 32'd0);
        checkOutput("rel_no_pulse", 32'(switchPulse), 32'd0);

        // Fresh reset, then load the four shadows with req low.
        rst_n = 1'b0;
        #1;
        data0 = 24'h111111;
        data1 = 24'h222222;
        data2 = 24'h333333;
        data3 = 24'h444444;
        applyStimulus(4'h0, 4'h0, 4'hF, 1'b0, 2'd0);
        waitEdge(1);
        rst_n = 1'b1;
        waitEdge(1);
        checkOutput("idle_src_valid", 32'(srcValid), 32'd0);

        // Round robin over 0,1,3 with dwell 8.
        applyStimulus(4'b1011, 4'h0, 4'h0, 1'b0, 2'd0);
        waitEdge(1);
        checkOutput("rr_A_src", 32'(curSrc), 32'd0);
        checkOutput("rr_A_pulse", 32'(switchPulse), 32'd0);
        waitEdge(1);
        checkOutput("rr_A1_data", 32'(dataOut), 32'h111111);
        checkOutput("rr_A1_valid", 32'(srcValid), 32'd1);
        waitEdge(6);
        checkOutput("rr_A7_src", 32'(curSrc), 32'd0);
        waitEdge(1);
        checkOutput("rr_A8_src", 32'(curSrc), 32'd1);
        checkOutput("rr_A8_pulse", 32'(switchPulse), 32'd1);
        checkOutput("rr_A8_data_trails", 32'(dataOut), 32'h111111);
        waitEdge(1);
        checkOutput("rr_A9_data", 32'(dataOut), 32'h222222);
        checkOutput("rr_A9_pulse", 32'(switchPulse), 32'd0);
        waitEdge(6);
        checkOutput("rr_A15_src", 32'(curSrc), 32'd1);
        waitEdge(1);
        checkOutput("rr_A16_src", 32'(curSrc), 32'd3);
        checkOutput("rr_A16_pulse", 32'(switchPulse), 32'd1);
        waitEdge(1);
        checkOutput("rr_A17_data", 32'(dataOut), 32'h444444);
        waitEdge(6);
        checkOutput("rr_A23_src", 32'(curSrc), 32'd3);
        waitEdge(1);
        checkOutput("rr_A24_src", 32'(curSrc), 32'd0);
        checkOutput("rr_A24_pulse", 32'(switchPulse), 32'd1);

        // Drop req[1] while it is shown with counter at 3.
        waitEdge(8);
        checkOutput("drop_A32_src", 32'(curSrc), 32'd1);
        waitEdge(3);
        req = 4'b1001;
        waitEdge(1);
        checkOutput("drop_next_src", 32'(curSrc), 32'd3);
        checkOutput("drop_pulse", 32'(switchPulse), 32'd1);
        waitEdge(7);
        checkOutput("drop_restart_hold", 32'(curSrc), 32'd3);
        waitEdge(1);
        checkOutput("drop_restart_expire", 32'(curSrc), 32'd0);
        req = 4'b0000;
        waitEdge(2);
        checkOutput("drop_all_valid", 32'(srcValid), 32'd0);
        checkOutput("drop_all_data", 32'(dataOut), 32'h000000);

        // Urgent preemption, lower-index preemption, then resume.
        req = 4'b0001;
        waitEdge(1);
        checkOutput("urg_B_src", 32'(curSrc), 32'd0);
        waitEdge(1);
        applyStimulus(4'b0101, 4'b0100, 4'h0, 1'b0, 2'd0);
        waitEdge(1);
        checkOutput("urg_enter_src", 32'(curSrc), 32'd2);
        checkOutput("urg_enter_pulse", 32'(switchPulse), 32'd1);
        waitEdge(1);
        checkOutput("urg_data", 32'(dataOut), 32'h333333);
        waitEdge(18);
        checkOutput("urg_held_20", 32'(curSrc), 32'd2);
        applyStimulus(4'b0111, 4'b0110, 4'h0, 1'b0, 2'd0);
        waitEdge(1);
        checkOutput("urg_lower_src", 32'(curSrc), 32'd1);
        checkOutput("urg_lower_pulse", 32'(switchPulse), 32'd1);
        urg = 4'b0000;
        waitEdge(1);
        checkOutput("urg_resume_src", 32'(curSrc), 32'd2);
        waitEdge(7);
        checkOutput("urg_resume_hold", 32'(curSrc), 32'd2);
        waitEdge(1);
        checkOutput("urg_resume_next", 32'(curSrc), 32'd0);

        // Manual selection with no requests, then back to auto.
        applyStimulus(4'b0000, 4'b0000, 4'h0, 1'b1, 2'd2);
        waitEdge(2);
        checkOutput("man_src", 32'(curSrc), 32'd2);
        checkOutput("man_valid", 32'(srcValid), 32'd1);
        checkOutput("man_data", 32'(dataOut), 32'h333333);
        mode = 1'b0;
        waitEdge(2);
        checkOutput("man_exit_valid", 32'(srcValid), 32'd0);
        checkOutput("man_exit_data", 32'(dataOut), 32'h000000);

        // Capture while shown, and capture coinciding with a switch.
        req = 4'b0001;
        waitEdge(1);
        checkOutput("cap_D_src", 32'(curSrc), 32'd0);
        data0 = 24'hABCDEF;
        upd   = 4'b0001;
        waitEdge(1);
        upd   = 4'b0000;
        waitEdge(1);
        checkOutput("cap_data0", 32'(dataOut), 32'hABCDEF);
        data1 = 24'h5A5A5A;
        applyStimulus(4'b0010, 4'h0, 4'b0010, 1'b0, 2'd0);
        waitEdge(1);
        checkOutput("cap_switch_src", 32'(curSrc), 32'd1);
        upd = 4'b0000;
        waitEdge(1);
        checkOutput("cap_switch_data", 32'(dataOut), 32'h5A5A5A);

        // Asynchronous reset mid-operation, sampled between edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_src", 32'(curSrc), 32'd0);
        checkOutput("async_rst_data", 32'(dataOut), 32'h000000);
        checkOutput("async_rst_valid", 32'(srcValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Time-shares the board's 6-digit seven-segment display among four requesting sources (e.g. UART status, SRAM address, SRAM data, CPU PC). Sits directly upstream of the display driver and feeds its 24-bit hex word. Each source's word is captured into a shadow register on an update strobe. The block rotates round-robin with a fixed dwell time, allows urgent preemption, and supports a manual switch-selected mode.

## Interface
- DWELL, 100_000_000, cycles each source stays on display in auto mode (≥2)
- CNT_W, 27, dwell counter width; must satisfy 2^CNT_W > DWELL
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  4  source i requests display time (level)
- urg  in  4  source i urgent; effective only with req[i]
- upd  in  4  1-cycle strobe: capture data_i into shadow i
- data0..data3  in  24 each  source words
- mode  in  1  0 = auto rotate, 1 = manual
- sel  in  2  manual source select
- data_out  out  24  word to display driver (registered)
- cur_src  out  2  source currently granted (registered)
- src_valid  out  1  1 when data_out belongs to a granted source
- switch_pulse  out  1  1-cycle pulse on the edge cur_src changes

## Operation
- Reset values:
  - shadows, data_out, cur_src, switch_pulse, src_valid, and the dwell counter are all 0.
  - State is IDLE.
  - The round-robin pointer `last` is 3, so the first search starts at 0.
- Capture: on upd[i], shadow[i] <= data_i. All four may strobe together. Capture is independent of grant and mode.
- Effective request: `er = req`. Urgent set: `u = req & urg`.
- States: IDLE, SHOW, URGENT, MANUAL. The mode input overrides all states.
- MANUAL (mode=1):
  - cur_src <= sel every cycle; src_valid = 1 regardless of req.
  - Counter is held at 0.
- Leaving MANUAL (mode 1→0), next-state selection:
  - If u≠0, go to URGENT.
  - Else if er[cur_src], go to SHOW keeping cur_src with counter 0.
  - Else pick the next requester after cur_src, or go to IDLE.
- IDLE:
  - src_valid = 0; data_out driven 0.
  - If u≠0, go to URGENT.
  - Else if er≠0, go to SHOW granting the first set bit searching last+1, last+2, … (mod 4).
- SHOW: counter increments each cycle.
  - If u≠0: go to URGENT immediately (takes priority over everything below).
  - Else if er[cur_src] drops: on the next edge, grant the next requester after cur_src, or go to IDLE. Counter resets to 0.
  - Else at counter == DWELL-1: grant the next requester after cur_src (wrapping, may re-select itself if it is the only requester). Counter resets to 0.
- URGENT:
  - cur_src = lowest index set in u.
  - Re-evaluated every cycle; a lower-index urgent source preempts a higher one.
  - Counter is held at 0.
  - When u==0: resume SHOW searching from the urgent source +1, or go to IDLE if er==0.
- `last` is updated to cur_src on every grant in SHOW/URGENT.
- data_out <= shadow[cur_src] every cycle in non-IDLE states. It therefore shows the post-capture value.
- switch_pulse = 1 on exactly the edge where the registered cur_src takes a different value. IDLE→SHOW with the same index does not pulse.

## Timing
- Grant latency: a request or urg change sampled at edge k → cur_src updated at edge k+1 → data_out updated at edge k+2.
- Update latency: upd[i] at edge k → shadow at k → data_out at k+1 if i is granted.
- Simultaneous events:
  - upd on the source being switched to is visible in the first data_out of the new grant.
  - Dwell expiry coinciding with req drop is handled as a drop (same outcome).
- A rotation period of a source is exactly DWELL cycles of cur_src stability.
- Reset asserted mid-operation forces all reset values asynchronously. After release, the first grant goes to the lowest requesting index.

## Test plan
- Reset: hold rst=0 with req=4'hF, upd=4'hF, data*=0xFFFFFF. Required: data_out=0, cur_src=0, src_valid=0, switch_pulse=0. After release, cur_src=0 on the first edge.
- Round robin: DWELL=8, shadows 0x111111/0x222222/0x333333/0x444444, req=4'b1011. Required: cur_src sequence 0,1,3,0, each held 8 cycles; switch_pulse at each change; data_out trails cur_src by 1 cycle.
- Drop: showing 1, drop req[1] at counter 3. Required: cur_src=3 next edge, counter restarts. Then drop all requests: IDLE, src_valid=0, data_out=0.
- Urgent: showing 0, assert req[2]&urg[2] for 20 cycles. Required: cur_src=2 next edge and held for 20 cycles. Adding urg[1] switches to 1. On release, rotation resumes from the urgent source +1.
- Manual: mode=1, sel=2, req=0. Required: cur_src=2, src_valid=1, data_out=0x333333. Then mode=0 with req=0: IDLE, data_out=0.
- Capture: while showing 0, pulse upd[0] with data0=0xABCDEF. Required: data_out=0xABCDEF one edge later. Also pulse upd[1] on the same edge as the switch 0→1: first data_out for source 1 is the new value.
